// File: rtl/arith_accum_pipe.sv
// Single-stage add/sub/accumulate unit with a valid/ready input, one registered
// output slot, and an internal accumulator updated by ACC and CLR operations.
module arith_accum_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] acc
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam int unsigned MSB = WIDTH - 1;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] opnd_x, opnd_y;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic             accept;

  // Handshake: a transfer happens on a rising edge when valid and ready are
  // both high. The output slot can take a new operation when it is empty or
  // is being drained on the same edge; reset keeps in_ready high.
  assign in_ready = rst || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !rst;

  // ACC reuses the adder with the accumulator as its first operand.
  assign opnd_x  = (op == OP_ACC) ? acc_q : a;
  assign opnd_y  = (op == OP_ACC) ? a : b;
  assign add_ext = {1'b0, opnd_x} + {1'b0, opnd_y};
  assign sub_ext = {1'b0, opnd_x} - {1'b0, opnd_y};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    acc_d      = acc_q;
    case (op)
      OP_ADD, OP_ACC: begin
        carry_d    = add_ext[WIDTH];
        overflow_d = (opnd_x[MSB] == opnd_y[MSB]) && (add_ext[MSB] != opnd_x[MSB]);
        result_d   = (SATURATE && carry_d) ? {WIDTH{1'b1}} : add_ext[WIDTH-1:0];
        if (op == OP_ACC) acc_d = result_d;
      end
      OP_SUB: begin
        carry_d    = sub_ext[WIDTH];
        overflow_d = (opnd_x[MSB] != opnd_y[MSB]) && (sub_ext[MSB] != opnd_x[MSB]);
        result_d   = (SATURATE && carry_d) ? '0 : sub_ext[WIDTH-1:0];
      end
      OP_CLR: begin
        acc_d = '0;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_arith_accum_pipe.sv
// Bench for arith_accum_pipe: wrapping and saturating instances share inputs,
// a reference model fills an expected queue that is drained on output transfers.
module tb_arith_accum_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0, carry0, overflow0;
  logic [7:0] result0, acc0;
  logic       in_ready1, out_valid1, carry1, overflow1;
  logic [7:0] result1, acc1;

  arith_accum_pipe #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .carry(carry0), .overflow(overflow0), .acc(acc0)
  );

  arith_accum_pipe #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .carry(carry1), .overflow(overflow1), .acc(acc1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // entry: {acc1, r1, c1, v1, acc0, r0, c0, v0}
  logic [35:0] exp_q[$];
  logic [7:0]  model_acc0 = 8'd0;
  logic [7:0]  model_acc1 = 8'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {new_acc, result, carry, overflow} computed with integer arithmetic.
  function automatic logic [17:0] model_op(input logic [1:0] o, input logic [7:0] x_a,
                                           input logic [7:0] x_b, input logic [7:0] cur_acc,
                                           input bit sat);
    int s, sx, sy;
    logic [7:0] x, y, r, nacc;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 8'd0; nacc = cur_acc;
    x = (o == 2'b10) ? cur_acc : x_a;
    y = (o == 2'b10) ? x_a : x_b;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (o)
      2'b00, 2'b10: begin
        s = int'(x) + int'(y);
        c = (s > 255);
        r = s[7:0];
        if (sat && c) r = 8'd255;
        v = ((sx + sy) > 127) || ((sx + sy) < -128);
        if (o == 2'b10) nacc = r;
      end
      2'b01: begin
        s = int'(x) - int'(y);
        c = (s < 0);
        r = s[7:0];
        if (sat && c) r = 8'd0;
        v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
      default: nacc = 8'd0;
    endcase
    return {nacc, r, c, v};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [7:0] x_a, input logic [7:0] x_b);
    logic [17:0] e0, e1;
    int waited;
    in_valid = 1'b1; op = o; a = x_a; b = x_b;
    waited = 0;
    @(negedge clk);
    while (!in_ready0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready0) begin
      check("accept_timeout", 32'(in_ready0), 32'd1);
    end else begin
      e0 = model_op(o, x_a, x_b, model_acc0, 1'b0);
      e1 = model_op(o, x_a, x_b, model_acc1, 1'b1);
      model_acc0 = e0[17:10];
      model_acc1 = e1[17:10];
      exp_q.push_back({e1, e0});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Asynchronous pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    model_acc0 = 8'd0;
    model_acc1 = 8'd0;
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_result",    32'(result0),    32'd0);
    check("rst_carry",     32'(carry0),     32'd0);
    check("rst_overflow",  32'(overflow0),  32'd0);
    check("rst_acc",       32'(acc0),       32'd0);
    check("rst_in_ready",  32'(in_ready0),  32'd1);
    check("rst_acc_sat",   32'(acc1),       32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && out_valid0 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid0), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wrap_result",   32'(result0),    32'(e[9:2]));
        check("wrap_carry",    32'(carry0),     32'(e[1]));
        check("wrap_overflow", 32'(overflow0),  32'(e[0]));
        check("wrap_acc",      32'(acc0),       32'(e[17:10]));
        check("sat_valid",     32'(out_valid1), 32'd1);
        check("sat_result",    32'(result1),    32'(e[27:20]));
        check("sat_carry",     32'(carry1),     32'(e[19]));
        check("sat_overflow",  32'(overflow1),  32'(e[18]));
        check("sat_acc",       32'(acc1),       32'(e[35:28]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("init_in_ready", 32'(in_ready0), 32'd1);
    check("init_out_valid", 32'(out_valid0), 32'd0);
    rst = 1'b0;
    reset_pulse();

    // Carry, borrow and signed overflow corners.
    out_ready = 1'b1;
    send(2'b00, 8'd200, 8'd100);
    send(2'b01, 8'd5, 8'd9);
    send(2'b00, 8'd100, 8'd100);
    send(2'b01, 8'd128, 8'd1);
    idle();
    @(posedge clk); #1;

    // Back-to-back accumulation, then clear.
    send(2'b10, 8'd10, 8'd0);
    send(2'b10, 8'd20, 8'd0);
    idle();
    @(negedge clk);
    check("acc_after_two", 32'(acc0), 32'd30);
    @(posedge clk); #1;
    send(2'b11, 8'd55, 8'd66);
    idle();
    @(negedge clk);
    check("acc_after_clr", 32'(acc0), 32'd0);
    check("clr_result", 32'(result0), 32'd0);
    @(posedge clk); #1;

    // Backpressure: held result, blocked input, replace on drain edge.
    out_ready = 1'b0;
    send(2'b00, 8'd1, 8'd2);
    a = 8'd9; b = 8'd9;
    repeat (3) begin
      @(negedge clk);
      check("hold_result", 32'(result0), 32'd3);
      check("hold_valid", 32'(out_valid0), 32'd1);
      check("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 8'd4, 8'd4);
    idle();
    @(negedge clk);
    check("replace_valid", 32'(out_valid0), 32'd1);
    check("replace_result", 32'(result0), 32'd8);
    @(posedge clk); #1;

    // Reset with a result still pending.
    out_ready = 1'b0;
    send(2'b10, 8'd7, 8'd0);
    idle();
    @(negedge clk);
    check("pending_acc", 32'(acc0), 32'd7);
    reset_pulse();
    out_ready = 1'b1;
    send(2'b10, 8'd1, 8'd0);
    idle();
    @(negedge clk);
    check("post_rst_result", 32'(result0), 32'd1);
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
